// File: rtl/instr_feed_queue.sv
// Instruction-feed FIFO between the machine-code source and decode.
// Each accepted word is tagged with its PC and an illegal-encoding flag; flush redirects the PC.
module instr_feed_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_code,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_illegal,
    input  logic                     flush,
    input  logic [PC_W-1:0]          flush_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high
    // and flush is low; ready never depends on the partner's valid in the same cycle.

    logic [XLEN-1:0] mem_code [DEPTH];
    logic [PC_W-1:0] mem_pc   [DEPTH];
    logic [DEPTH-1:0] mem_ill;

    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count_q;
    logic [PC_W-1:0] next_pc;

    logic push;
    logic pop;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    // Head is read straight from storage; outputs are forced to zero while empty.
    assign out_code    = out_valid ? mem_code[rptr] : '0;
    assign out_pc      = out_valid ? mem_pc[rptr]   : '0;
    assign out_illegal = out_valid ? mem_ill[rptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_code[wptr] <= in_code;
            mem_pc[wptr]   <= next_pc;
            mem_ill[wptr]  <= (in_code[1:0] != 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            next_pc <= PC_W'(RESET_PC);
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            next_pc <= flush_pc;
        end else begin
            if (push) begin
                wptr    <= wptr + AW'(1);
                next_pc <= next_pc + PC_W'(PC_STEP);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_feed_queue.sv
// Bench for instr_feed_queue: directed scenarios plus random traffic against a queue model.
module tb_instr_feed_queue;

    localparam int DEPTH = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (PC_W = 32)
    logic        reset, in_valid, out_ready, flush;
    logic [31:0] in_code, flush_pc;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_code, out_pc;
    logic [3:0]  count;

    instr_feed_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_W(32), .RESET_PC(0), .PC_STEP(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_pc(out_pc),
        .out_illegal(out_illegal), .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    // narrow-PC instance for wrap checking
    logic        reset_b, in_valid_b, out_ready_b, flush_b;
    logic [31:0] in_code_b;
    logic [7:0]  flush_pc_b;
    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [31:0] out_code_b;
    logic [7:0]  out_pc_b;
    logic [3:0]  count_b;

    instr_feed_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_W(8), .RESET_PC(0), .PC_STEP(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_code(in_code_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_code(out_code_b), .out_pc(out_pc_b),
        .out_illegal(out_illegal_b), .flush(flush_b), .flush_pc(flush_pc_b), .count(count_b)
    );

    // scoreboard: each entry is {illegal, pc, code}
    logic [64:0] exp_q[$];
    logic [31:0] m_pc;
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] code, input logic r,
                         input logic f, input logic [31:0] fpc);
        in_valid  = v;
        in_code   = code;
        out_ready = r;
        flush     = f;
        flush_pc  = fpc;
    endtask

    // Reference behaviour at one clock edge, from the queue's rules.
    task automatic model_edge();
        logic do_push, do_pop;
        if (reset) begin
            exp_q.delete();
            m_pc = 32'h0;
        end else if (flush) begin
            exp_q.delete();
            m_pc = flush_pc;
        end else begin
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = out_ready && (exp_q.size() > 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({(in_code[1:0] != 2'b11), m_pc, in_code});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        logic [64:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : 65'h0;
        check("count", 64'(count), 64'(exp_q.size()));
        check("count_range", 64'(count <= DEPTH), 64'd1);
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("out_code", 64'(out_code), 64'(h[31:0]));
        check("out_pc", 64'(out_pc), 64'(h[63:32]));
        check("out_illegal", 64'(out_illegal), 64'(h[64]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset_b = 1'b1; in_valid_b = 1'b0; in_code_b = 32'h0; out_ready_b = 1'b0;
        flush_b = 1'b0; flush_pc_b = 8'h0;
        m_pc = 32'h0;

        // 1: reset then single push
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        drive(1'b1, 32'h00040413, 1'b0, 1'b0, 32'h0);
        step();
        check("t1_code", 64'(out_code), 64'h00040413);
        check("t1_pc", 64'(out_pc), 64'h0);
        check("t1_count", 64'(count), 64'd1);

        // 2: fill, offer a ninth, drain in order
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h00000013 + 32'(k), 1'b0, 1'b0, 32'h0);
            step();
        end
        check("t2_full_count", 64'(count), 64'd8);
        check("t2_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hDEAD0013, 1'b0, 1'b0, 32'h0);
        step();
        check("t2_no_ninth", 64'(count), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check("t2_drain_pc", 64'(out_pc), 64'(4 * k));
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            step();
        end
        check("t2_empty", 64'(out_valid), 64'd0);

        // 3: full with push+pop -> only pop; then both -> steady
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h100 + 32'(k) * 4 + 3, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0);
        step();
        check("t3_pop_only", 64'(count), 64'd7);
        step();
        check("t3_both", 64'(count), 64'd7);

        // 4: flush with pending push
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00000033, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h00000077, 1'b1, 1'b1, 32'h100);
        step();
        check("t4_flush_count", 64'(count), 64'd0);
        check("t4_flush_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h00000093, 1'b0, 1'b0, 32'h0);
        step();
        check("t4_pc0", 64'(out_pc), 64'h100);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        check("t4_pc1", 64'(out_pc), 64'h104);

        // 5: illegal flag
        do_reset();
        drive(1'b1, 32'h00000002, 1'b0, 1'b0, 32'h0);
        step();
        check("t5_ill", 64'(out_illegal), 64'd1);
        check("t5_ill_code", 64'(out_code), 64'h2);
        drive(1'b1, 32'h00000003, 1'b1, 1'b0, 32'h0);
        step();
        check("t5_legal", 64'(out_illegal), 64'd0);
        check("t5_legal_code", 64'(out_code), 64'h3);

        // 6a: reset overrides flush
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
            step();
        end
        reset = 1'b1;
        drive(1'b1, 32'h00000013, 1'b1, 1'b1, 32'h40);
        step();
        reset = 1'b0;
        check("t6_rst_count", 64'(count), 64'd0);
        drive(1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
        step();
        check("t6_rst_pc", 64'(out_pc), 64'h0);

        // 6b: PC wrap on the 8-bit instance
        reset_b = 1'b0;
        flush_b = 1'b1; flush_pc_b = 8'hFC;
        @(posedge clk); #1;
        check("t6_b_flush_count", 64'(count_b), 64'd0);
        flush_b = 1'b0; in_valid_b = 1'b1; in_code_b = 32'h00000013;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        check("t6_b_count", 64'(count_b), 64'd2);
        check("t6_b_pc0", 64'(out_pc_b), 64'hFC);
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        check("t6_b_pc1", 64'(out_pc_b), 64'h00);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 65, $urandom(), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 4, $urandom());
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
